// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes, widths and the ID/EX beat struct
// Contents: default widths, ALU opcode constants, packed id_ex_t decode beat.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int OPC_W     = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [OPC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OPC_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OPC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPC_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [OPC_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [OPC_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [OPC_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [OPC_W-1:0] ALU_SRA = 4'b0111;
    localparam logic [OPC_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [OPC_W-1:0] ALU_SLT = 4'b1001;

    typedef struct packed {
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rs1_addr;
        logic [REG_IDX_W-1:0] rs2_addr;
        logic [REG_IDX_W-1:0] rd_addr;
        logic                 alu_src;
        logic [OPC_W-1:0]     alu_op;
        logic                 reg_write;
    } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select for one source register
// Ports: rs_addr/rs_data (registered operand), exmem_*/memwb_* (forwarding
// sources), data (selected operand).
// Macro ID_EX_FWD_EN: when defined, EX/MEM then MEM/WB results override the
// registered operand; when undefined the registered operand passes through.
module fwd_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_ADDR_W = REG_IDX_W
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] data
);

`ifdef ID_EX_FWD_EN
    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired to zero, so a pending write to it must never be forwarded.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        data = rs_data;
        if (exmem_hit)
            data = exmem_result;
        else if (memwb_hit)
            data = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, exmem_rd, exmem_reg_write, exmem_result,
                          memwb_rd, memwb_reg_write, memwb_result};
    assign data = rs_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - one-entry ID/EX pipeline register with valid/ready and forwarding
// Ports: clk, reset (sync active-low); in_valid/in_ready + decode fields in;
// exmem_*/memwb_* forwarding sources; flush; out_valid/out_ready + SrcA, SrcB,
// Operation, store_data, rd_out, reg_write_out out.
// Macro ID_EX_FWD_EN enables operand forwarding inside fwd_unit.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int OPCODE_LENGTH = OPC_W,
    parameter int REG_ADDR_W    = REG_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [REG_ADDR_W-1:0]    rs1_addr,
    input  logic [REG_ADDR_W-1:0]    rs2_addr,
    input  logic [REG_ADDR_W-1:0]    rd_addr,
    input  logic                     alu_src,
    input  logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic                     reg_write,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     exmem_reg_write,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [REG_ADDR_W-1:0]    rd_out,
    output logic                     reg_write_out
);

    logic [DATA_WIDTH-1:0]    rs1_q;
    logic [DATA_WIDTH-1:0]    rs2_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic [REG_ADDR_W-1:0]    rs1_addr_q;
    logic [REG_ADDR_W-1:0]    rs2_addr_q;
    logic [REG_ADDR_W-1:0]    rd_q;
    logic                     alu_src_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     reg_write_q;
    logic [DATA_WIDTH-1:0]    fwd_rs1;
    logic [DATA_WIDTH-1:0]    fwd_rs2;

    // Accept when empty or when the held beat leaves this same edge.
    assign in_ready = !flush && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            alu_src_q   <= 1'b0;
            op_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            rs1_q       <= rs1_data;
            rs2_q       <= rs2_data;
            imm_q       <= imm;
            rs1_addr_q  <= rs1_addr;
            rs2_addr_q  <= rs2_addr;
            rd_q        <= rd_addr;
            alu_src_q   <= alu_src;
            op_q        <= alu_op;
            reg_write_q <= reg_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr         (rs1_addr_q),
        .rs_data         (rs1_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (fwd_rs1)
    );

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr         (rs2_addr_q),
        .rs_data         (rs2_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (fwd_rs2)
    );

    assign SrcA          = fwd_rs1;
    assign SrcB          = alu_src_q ? imm_q : fwd_rs2;
    assign store_data    = fwd_rs2;
    assign Operation     = op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = out_valid && reg_write_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand/result width; OPCODE_LENGTH, 4, ALU operation code width; REG_ADDR_W, 5, register index width.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 sole clock, rising edge; reset in 1 synchronous active-low reset.
REQ-003 in_valid in 1 decode beat valid; in_ready out 1 stage can accept the beat.
REQ-004 rs1_data, rs2_data, imm in DATA_WIDTH register-file operands and immediate; rs1_addr, rs2_addr, rd_addr in REG_ADDR_W register indices.
REQ-005 alu_src in 1 SrcB = imm when 1; alu_op in OPCODE_LENGTH ALU operation; reg_write in 1 instruction writes rd.
REQ-006 exmem_rd, memwb_rd in REG_ADDR_W; exmem_reg_write, memwb_reg_write in 1; exmem_result, memwb_result in DATA_WIDTH forwarding sources.
REQ-007 flush in 1 squash held and incoming beats.
REQ-008 out_valid out 1; out_ready in 1 execute side accepts; SrcA, SrcB out DATA_WIDTH ALU operands; Operation out OPCODE_LENGTH; store_data out DATA_WIDTH forwarded rs2; rd_out out REG_ADDR_W; reg_write_out out 1.

Function
REQ-009 Stage SHALL hold one beat; in_ready = !out_valid || out_ready, forced 0 while flush=1.
REQ-010 Beat transfers on rising clk when in_valid && in_ready; fields captured, out_valid <= 1, latency exactly one cycle.
REQ-011 Output consumed when out_valid && out_ready; if no new beat captured same edge, out_valid <= 0.
REQ-012 Simultaneous consume and capture SHALL replace held beat with no bubble (full throughput).
REQ-013 While out_valid && !out_ready all registered fields SHALL stay constant; in_valid data SHALL NOT be captured.
REQ-014 flush=1 SHALL set out_valid <= 0 next edge, discard held beat, capture nothing; flush takes priority over every handshake.
REQ-015 Forwarding SHALL be combinational from registered rs addresses/data: if exmem_reg_write && exmem_rd != 0 && exmem_rd == rsX use exmem_result; else if memwb_reg_write && memwb_rd != 0 && memwb_rd == rsX use memwb_result; else registered rsX data.
REQ-016 EX/MEM SHALL win when both sources match; register x0 SHALL never be forwarded.
REQ-017 SrcA = forwarded rs1; SrcB = imm if alu_src else forwarded rs2; store_data = forwarded rs2 regardless of alu_src.
REQ-018 Operation, rd_out, reg_write_out SHALL be the registered alu_op, rd_addr, reg_write; reg_write_out SHALL be 0 whenever out_valid=0.

Reset
REQ-019 With reset=0 at a rising edge: out_valid=0, all registered fields 0 (Operation=4'b0000, rd_out=0, SrcA=SrcB=store_data=0 absent forwarding); reset overrides flush and handshakes.
REQ-020 Beat in flight during reset SHALL be dropped; in_ready SHALL be 1 on first cycle after reset release.

Configuration
REQ-021 Macro ID_EX_FWD_EN defined: forwarding per REQ-015..016.
REQ-022 Undefined: SrcA/SrcB/store_data from registered operands only; forwarding ports present, ignored.

Structure
REQ-023 Shared package riscv_pkg SHALL hold ALU opcode constants (AND 0000, SUB 0001, ADD 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, EQ 1000, SLT 1001) and the packed id_ex_t beat struct.
REQ-024 Forwarding select logic SHALL be sub-module fwd_unit, instantiated twice (rs1, rs2).

Verification
REQ-025 Reset, then in_valid, rs1_data=5, rs2_data=7, alu_op=0010, out_ready=1 -> next cycle out_valid=1, SrcA=5, SrcB=7, Operation=0010.
REQ-026 out_ready=0 three cycles with held beat, new in_valid -> in_ready=0, outputs stable; out_ready=1 -> back-to-back transfer, no bubble.
REQ-027 Held rs1_addr=3; exmem_rd=3, exmem_reg_write=1, result=0xAA; memwb_rd=3, result=0xBB -> SrcA=0xAA; exmem_reg_write=0 -> SrcA=0xBB.
REQ-028 rs1_addr=0, exmem_rd=0, exmem_reg_write=1, result=0xFF -> SrcA=registered rs1_data; alu_src=1, imm=0x10 -> SrcB=0x10, store_data=forwarded rs2.
REQ-029 flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, next cycle out_valid=0, reg_write_out=0.
REQ-030 reset=0 mid-stall -> next cycle out_valid=0, in_ready=1; repeat REQ-027 with ID_EX_FWD_EN undefined -> SrcA=registered rs1_data.
